// File: rtl/ws2812_rx_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 NRZ receiver.
package ws2812_rx_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH,
        LOW
    } ws2812_rx_state_t;

    localparam int unsigned PIX_W          = 24;
    localparam int unsigned DEF_T_BIT_THR  = 30;
    localparam int unsigned DEF_T_HIGH_MIN = 5;
    localparam int unsigned DEF_T_HIGH_MAX = 75;
    localparam int unsigned DEF_T_RST_MIN  = 2500;
    localparam int unsigned DEF_IDX_W      = 8;

endpackage

// File: rtl/ws2812_rx_sync.sv
// Input conditioning for the WS2812 line: 2-FF synchronizer, optional 3-sample
// majority filter (WS2812_RX_GLITCH_FILTER_EN) and registered rise/fall strobes.
module ws2812_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic din_lvl,
    output logic rise,
    output logic fall
);

    logic din_meta;
    logic din_s;
    logic lvl_prev;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
        end
    end

`ifdef WS2812_RX_GLITCH_FILTER_EN
    // Two older samples plus the current one; a level must persist two cycles to pass.
    logic [1:0] din_hist;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            din_hist <= 2'b00;
        end else begin
            din_hist <= {din_hist[0], din_s};
        end
    end

    assign din_lvl = (din_s & din_hist[0]) | (din_s & din_hist[1]) | (din_hist[0] & din_hist[1]);
`else
    assign din_lvl = din_s;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lvl_prev <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            lvl_prev <= din_lvl;
            rise     <= din_lvl & ~lvl_prev;
            fall     <= ~din_lvl & lvl_prev;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ decoder: classifies high pulses into bits, assembles 24-bit GRB pixels
// and detects the frame-ending low gap. WS2812_RX_GLITCH_FILTER_EN adds a spike filter.
module ws2812_rx
    import ws2812_rx_pkg::*;
#(
    parameter int unsigned T_BIT_THR  = DEF_T_BIT_THR,
    parameter int unsigned T_HIGH_MIN = DEF_T_HIGH_MIN,
    parameter int unsigned T_HIGH_MAX = DEF_T_HIGH_MAX,
    parameter int unsigned T_RST_MIN  = DEF_T_RST_MIN,
    parameter int unsigned IDX_W      = DEF_IDX_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             din,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_grb,
    output logic [IDX_W-1:0] pix_idx,
    output logic             frame_done,
    output logic [IDX_W-1:0] frame_len,
    output logic             err,
    output logic             busy
);

    localparam int unsigned HC_W = $clog2(T_HIGH_MAX + 1);
    localparam int unsigned LC_W = $clog2(T_RST_MIN + 1);

    localparam logic [HC_W-1:0] HIGH_MAX_C = HC_W'(T_HIGH_MAX);
    localparam logic [HC_W-1:0] HIGH_MIN_C = HC_W'(T_HIGH_MIN);
    localparam logic [HC_W-1:0] BIT_THR_C  = HC_W'(T_BIT_THR);
    localparam logic [LC_W-1:0] RST_LAST_C = LC_W'(T_RST_MIN - 1);
    localparam logic [4:0]      LAST_BIT_C = 5'(PIX_W - 1);

    logic din_lvl;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .din       (din),
        .din_lvl   (din_lvl),
        .rise      (rise),
        .fall      (fall)
    );

    ws2812_rx_state_t state, state_nxt;
    logic [HC_W-1:0]  hcnt, hcnt_nxt;
    logic [LC_W-1:0]  lcnt, lcnt_nxt;
    logic [PIX_W-1:0] sreg, sreg_nxt;
    logic [4:0]       bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0] pix_cnt, pix_cnt_nxt;
    logic             pix_valid_nxt;
    logic [PIX_W-1:0] pix_grb_nxt;
    logic [IDX_W-1:0] pix_idx_nxt;
    logic             frame_done_nxt;
    logic [IDX_W-1:0] frame_len_nxt;
    logic             err_nxt;
    logic             busy_nxt;
    logic             new_bit;

    assign new_bit = (hcnt >= BIT_THR_C);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= SYNC;
            hcnt       <= '0;
            lcnt       <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            pix_valid  <= 1'b0;
            pix_grb    <= '0;
            pix_idx    <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            lcnt       <= lcnt_nxt;
            sreg       <= sreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            pix_cnt    <= pix_cnt_nxt;
            pix_valid  <= pix_valid_nxt;
            pix_grb    <= pix_grb_nxt;
            pix_idx    <= pix_idx_nxt;
            frame_done <= frame_done_nxt;
            frame_len  <= frame_len_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hcnt_nxt       = hcnt;
        lcnt_nxt       = lcnt;
        sreg_nxt       = sreg;
        bit_cnt_nxt    = bit_cnt;
        pix_cnt_nxt    = pix_cnt;
        pix_valid_nxt  = 1'b0;
        pix_grb_nxt    = pix_grb;
        pix_idx_nxt    = pix_idx;
        frame_done_nxt = 1'b0;
        frame_len_nxt  = frame_len;
        err_nxt        = 1'b0;
        busy_nxt       = busy;

        unique case (state)
            // Any error lands here, so the frame counters are flushed while waiting.
            SYNC: begin
                busy_nxt    = 1'b0;
                bit_cnt_nxt = '0;
                pix_cnt_nxt = '0;
                if (rise || din_lvl) begin
                    lcnt_nxt = '0;
                end else if (lcnt >= RST_LAST_C) begin
                    lcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    lcnt_nxt = lcnt + 1'b1;
                end
            end

            IDLE: begin
                if (rise) begin
                    hcnt_nxt  = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = HIGH;
                end
            end

            HIGH: begin
                if (hcnt >= HIGH_MAX_C) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    lcnt_nxt  = '0;
                    state_nxt = SYNC;
                end else if (fall) begin
                    lcnt_nxt = '0;
                    if (hcnt < HIGH_MIN_C) begin
                        err_nxt   = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = SYNC;
                    end else begin
                        sreg_nxt  = {sreg[PIX_W-2:0], new_bit};
                        state_nxt = LOW;
                        if (bit_cnt == LAST_BIT_C) begin
                            bit_cnt_nxt   = '0;
                            pix_valid_nxt = 1'b1;
                            pix_grb_nxt   = {sreg[PIX_W-2:0], new_bit};
                            pix_idx_nxt   = pix_cnt;
                            pix_cnt_nxt   = pix_cnt + 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    hcnt_nxt = hcnt + 1'b1;
                end
            end

            // A partial pixel at the gap is dropped but the frame still reports its length.
            LOW: begin
                if (rise) begin
                    hcnt_nxt  = '0;
                    state_nxt = HIGH;
                end else if (lcnt >= RST_LAST_C) begin
                    lcnt_nxt       = '0;
                    frame_done_nxt = 1'b1;
                    frame_len_nxt  = pix_cnt;
                    err_nxt        = (bit_cnt != 5'd0);
                    pix_cnt_nxt    = '0;
                    bit_cnt_nxt    = '0;
                    busy_nxt       = 1'b0;
                    state_nxt      = IDLE;
                end else begin
                    lcnt_nxt = lcnt + 1'b1;
                end
            end

            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives NRZ pixels and gaps, records output strobes
// and compares them against hand-computed pixel data, indices and frame lengths.
module tb_ws2812_rx;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        din;
    logic        pix_valid;
    logic [23:0] pix_grb;
    logic [7:0]  pix_idx;
    logic        frame_done;
    logic [7:0]  frame_len;
    logic        err;
    logic        busy;

    int checks;
    int errors;
    int cyc;
    int last_fall_cyc;
    int bit23_fall_cyc;

    logic [23:0] pv_grb[$];
    logic [7:0]  pv_idx[$];
    int          pv_cyc[$];
    logic [7:0]  fd_len[$];
    int          err_cnt;
    int          fd_err_cnt;
    int          both_cnt;

    int pv_base;
    int fd_base;
    int err_base;
    int fd_err_base;

`ifdef WS2812_RX_GLITCH_FILTER_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 4;
`endif

    ws2812_rx dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (din),
        .pix_valid  (pix_valid),
        .pix_grb    (pix_grb),
        .pix_idx    (pix_idx),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .err        (err),
        .busy       (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output recorder, sampled mid-cycle away from the active edge.
    initial begin
        err_cnt    = 0;
        fd_err_cnt = 0;
        both_cnt   = 0;
    end

    always @(negedge sys_clk) begin
        if (pix_valid) begin
            pv_grb.push_back(pix_grb);
            pv_idx.push_back(pix_idx);
            pv_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_len.push_back(frame_len);
            if (err) fd_err_cnt = fd_err_cnt + 1;
        end
        if (err) err_cnt = err_cnt + 1;
        if (pix_valid && frame_done) both_cnt = both_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        din = 1'b1;
        repeat (b ? 40 : 20) @(negedge sys_clk);
        din = 1'b0;
        last_fall_cyc = cyc;
        repeat (b ? 22 : 42) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic [23:0] pixel, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) begin
            sendBit(pixel[i]);
        end
    endtask

    task automatic lowGap(input int n);
        din = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic markBase();
        pv_base     = pv_grb.size();
        fd_base     = fd_len.size();
        err_base    = err_cnt;
        fd_err_base = fd_err_cnt;
    endtask

    task automatic checkPixel(input string tag, input int i, input logic [23:0] grb, input logic [7:0] idx);
        logic [23:0] g;
        logic [7:0]  x;
        g = (pv_grb.size() > pv_base + i) ? pv_grb[pv_base + i] : 24'hxxxxxx;
        x = (pv_idx.size() > pv_base + i) ? pv_idx[pv_base + i] : 8'hxx;
        checkOutput({tag, "_grb"}, 32'(g), 32'(grb));
        checkOutput({tag, "_idx"}, 32'(x), 32'(idx));
    endtask

    task automatic checkFrame(input string tag, input int pixels, input int frames, input int errs, input logic [7:0] len);
        logic [7:0] l;
        checkOutput({tag, "_pv_count"}, 32'(pv_grb.size() - pv_base), 32'(pixels));
        checkOutput({tag, "_fd_count"}, 32'(fd_len.size() - fd_base), 32'(frames));
        checkOutput({tag, "_err_count"}, 32'(err_cnt - err_base), 32'(errs));
        if (frames > 0) begin
            l = (fd_len.size() > fd_base) ? fd_len[fd_base] : 8'hxx;
            checkOutput({tag, "_frame_len"}, 32'(l), 32'(len));
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        din       = 1'b0;
        sys_rst_n = 1'b0;
        pv_base   = 0;
        fd_base   = 0;
        err_base  = 0;
        fd_err_base = 0;
        last_fall_cyc  = 0;
        bit23_fall_cyc = 0;

        repeat (3) @(negedge sys_clk);
        checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
        checkOutput("rst_pix_grb", 32'(pix_grb), 32'd0);
        checkOutput("rst_pix_idx", 32'(pix_idx), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_frame_len", 32'(frame_len), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        sys_rst_n = 1'b1;

        // Pixel straight after reset, before any gap, must be ignored.
        markBase();
        applyStimulus(24'hFF8000, 24);
        lowGap(20);
        checkOutput("nogap_pv_count", 32'(pv_grb.size() - pv_base), 32'd0);
        checkOutput("nogap_busy", 32'(busy), 32'd0);
        lowGap(2560);

        // Single pixel frame with latency measurement.
        markBase();
        applyStimulus(24'hFF8000, 24);
        bit23_fall_cyc = last_fall_cyc;
        checkOutput("one_busy_mid", 32'(busy), 32'd1);
        lowGap(2560);
        checkFrame("one", 1, 1, 0, 8'd1);
        checkPixel("one_p0", 0, 24'hFF8000, 8'd0);
        checkOutput("one_latency", 32'((pv_cyc.size() > pv_base) ? pv_cyc[pv_base] - bit23_fall_cyc : -1), 32'(EXP_LAT));
        checkOutput("one_busy_end", 32'(busy), 32'd0);

        // Three pixels back to back.
        markBase();
        applyStimulus(24'h123456, 24);
        applyStimulus(24'hABCDEF, 24);
        applyStimulus(24'h000001, 24);
        lowGap(2560);
        checkFrame("three", 3, 1, 0, 8'd3);
        checkPixel("three_p0", 0, 24'h123456, 8'd0);
        checkPixel("three_p1", 1, 24'hABCDEF, 8'd1);
        checkPixel("three_p2", 2, 24'h000001, 8'd2);

        // Partial pixel: error coincides with frame_done.
        markBase();
        applyStimulus(24'hA5F00F, 12);
        lowGap(2560);
        checkFrame("partial", 0, 1, 1, 8'd0);
        checkOutput("partial_err_with_fd", 32'(fd_err_cnt - fd_err_base), 32'd1);

        // Over-long high pulse mid-pixel, then recovery.
        markBase();
        applyStimulus(24'hC3C3C3, 10);
        din = 1'b1;
        repeat (80) @(negedge sys_clk);
        lowGap(2560);
        checkFrame("longhi", 0, 0, 1, 8'd0);
        markBase();
        applyStimulus(24'hABCDEF, 24);
        lowGap(2560);
        checkFrame("recover", 1, 1, 0, 8'd1);
        checkPixel("recover_p0", 0, 24'hABCDEF, 8'd0);

        // One-cycle spike inside the frame gap.
        markBase();
        applyStimulus(24'h5A5A5A, 24);
        lowGap(100);
        din = 1'b1;
        @(negedge sys_clk);
        lowGap(2560);
`ifdef WS2812_RX_GLITCH_FILTER_EN
        checkFrame("spike", 1, 1, 0, 8'd1);
`else
        checkFrame("spike", 1, 0, 1, 8'd0);
`endif
        checkPixel("spike_p0", 0, 24'h5A5A5A, 8'd0);

        // Asynchronous reset mid-frame, then a pixel with no gap is ignored.
        markBase();
        applyStimulus(24'h0F0F0F, 12);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        applyStimulus(24'h00FF00, 24);
        lowGap(30);
        checkOutput("abort_pv_count", 32'(pv_grb.size() - pv_base), 32'd0);
        lowGap(2560);
        markBase();
        applyStimulus(24'h800001, 24);
        lowGap(2560);
        checkFrame("after_abort", 1, 1, 0, 8'd1);
        checkPixel("after_abort_p0", 0, 24'h800001, 8'd0);

        checkOutput("pv_fd_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
